// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves EX-stage conditional branches by borrowing the
// shared ALU for the compare, then checks the outcome against the prediction.
// Ports: i_br_valid/o_br_ready accept a branch op (func3, pc, imm, rs1, rs2,
//   prediction); o_alu_req/i_alu_gnt/o_alu_op/o_alu_a/o_alu_b request the ALU;
//   i_alu_valid/i_alu_result return the compare; o_done/o_taken/o_redirect/
//   o_flush/o_redirect_pc/o_err report the resolution; i_kill squashes it.
module branch_resolve_ctrl #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_br_valid,
   output logic            o_br_ready,
   input  logic [2:0]      i_func3,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic            i_pred_taken,
   input  logic            i_kill,
   output logic            o_alu_req,
   input  logic            i_alu_gnt,
   output logic [1:0]      o_alu_op,
   output logic [XLEN-1:0] o_alu_a,
   output logic [XLEN-1:0] o_alu_b,
   input  logic            i_alu_valid,
   input  logic [XLEN-1:0] i_alu_result,
   output logic            o_done,
   output logic            o_taken,
   output logic            o_redirect,
   output logic            o_flush,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic            o_err
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_WAIT,
      S_RESOLVE,
      S_DRAIN
   } state_t;

   state_t          r_state;
   logic [2:0]      r_func3;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_rs1;
   logic [XLEN-1:0] r_rs2;
   logic            r_pred;
   logic [CW-1:0]   r_cnt;
   logic            r_done;
   logic            r_taken;
   logic            r_redir;
   logic            r_err;
   logic [XLEN-1:0] r_rpc;

   logic            w_legal;
   logic            w_arb;
   logic [CW-1:0]   w_cnt_inc;
   logic            w_tmo;
   logic            w_end;
   logic            w_inv;
   logic            w_taken;
   logic            w_mis;
   logic [XLEN-1:0] w_tgt;
   logic            w_unused;

   // func3 010/011 are not branches: resolved not-taken without the ALU
   assign w_legal   = (i_func3[2:1] != 2'b01);
   assign w_arb     = (r_state == S_ARB);
   assign w_cnt_inc = r_cnt + 1'b1;
   // counter runs from grant, so the last allowed cycle is TIMEOUT-1 after it
   assign w_tmo     = (w_cnt_inc == CNT_LAST);
   assign w_end     = i_alu_valid | w_tmo;
   // BNE, BLT and BLTU are taken when the EQ/GE/GEU compare is false
   assign w_inv     = r_func3[0] ^ r_func3[2];
   assign w_taken   = i_alu_valid & (i_alu_result[0] ^ w_inv);
   assign w_mis     = w_taken ^ r_pred;
   assign w_tgt     = w_taken ? r_pc + r_imm : r_pc + PC_STEP;
   assign w_unused  = ^i_alu_result[XLEN-1:1];

   assign o_br_ready = (r_state == S_IDLE);
   assign o_alu_req  = w_arb;
   assign o_alu_op   = (w_arb && r_func3[2]) ?
                       {r_func3[1], ~r_func3[1]} : 2'b00;
   assign o_alu_a    = w_arb ? r_rs1 : '0;
   assign o_alu_b    = w_arb ? r_rs2 : '0;

   // a kill during the resolve cycle squashes the registered pulses
   assign o_done        = r_done  & ~i_kill;
   assign o_taken       = r_taken & ~i_kill;
   assign o_redirect    = r_redir & ~i_kill;
   assign o_flush       = r_redir & ~i_kill;
   assign o_err         = r_err   & ~i_kill;
   assign o_redirect_pc = r_rpc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_func3 <= '0;
         r_pc    <= '0;
         r_imm   <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_pred  <= 1'b0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_taken <= 1'b0;
         r_redir <= 1'b0;
         r_err   <= 1'b0;
         r_rpc   <= '0;
      end else begin
         r_done  <= 1'b0;
         r_taken <= 1'b0;
         r_redir <= 1'b0;
         r_err   <= 1'b0;
         r_rpc   <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (i_br_valid) begin
                  r_func3 <= i_func3;
                  r_pc    <= i_pc;
                  r_imm   <= i_imm;
                  r_rs1   <= i_rs1;
                  r_rs2   <= i_rs2;
                  r_pred  <= i_pred_taken;
                  if (w_legal) begin
                     r_state <= S_ARB;
                  end else begin
                     r_state <= S_RESOLVE;
                     r_done  <= 1'b1;
                     r_redir <= i_pred_taken;
                     r_rpc   <= i_pred_taken ? i_pc + PC_STEP : '0;
                  end
               end
            end
            S_ARB: begin
               if (i_kill) begin
                  // a granted op still returns a result that must drain
                  r_state <= i_alu_gnt ? S_DRAIN : S_IDLE;
                  r_cnt   <= '0;
               end else if (i_alu_gnt) begin
                  r_state <= S_WAIT;
                  r_cnt   <= '0;
               end
            end
            S_WAIT: begin
               r_cnt <= w_cnt_inc;
               if (w_end) begin
                  if (i_kill) begin
                     // result or timeout lands this cycle: nothing to drain
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_RESOLVE;
                     r_done  <= 1'b1;
                     r_taken <= w_taken;
                     r_err   <= ~i_alu_valid;
                     r_redir <= w_mis;
                     r_rpc   <= w_mis ? w_tgt : '0;
                  end
               end else if (i_kill) begin
                  r_state <= S_DRAIN;
               end
            end
            S_RESOLVE: begin
               r_state <= S_IDLE;
            end
            S_DRAIN: begin
               r_cnt <= w_cnt_inc;
               if (w_end) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and randomized branch transactions checked
// cycle by cycle against a per-transaction timeline model.
module tb_branch_resolve_ctrl;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            br_valid = 1'b0;
   logic            br_ready;
   logic [2:0]      func3 = '0;
   logic [XLEN-1:0] pc = '0;
   logic [XLEN-1:0] imm = '0;
   logic [XLEN-1:0] rs1 = '0;
   logic [XLEN-1:0] rs2 = '0;
   logic            pred = 1'b0;
   logic            kill = 1'b0;
   logic            alu_req;
   logic            alu_gnt = 1'b0;
   logic [1:0]      alu_op;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic            alu_valid = 1'b0;
   logic [XLEN-1:0] alu_result = '0;
   logic            done;
   logic            taken;
   logic            redirect;
   logic            flush;
   logic [XLEN-1:0] redirect_pc;
   logic            err;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_br_valid    (br_valid),
      .o_br_ready    (br_ready),
      .i_func3       (func3),
      .i_pc          (pc),
      .i_imm         (imm),
      .i_rs1         (rs1),
      .i_rs2         (rs2),
      .i_pred_taken  (pred),
      .i_kill        (kill),
      .o_alu_req     (alu_req),
      .i_alu_gnt     (alu_gnt),
      .o_alu_op      (alu_op),
      .o_alu_a       (alu_a),
      .o_alu_b       (alu_b),
      .i_alu_valid   (alu_valid),
      .i_alu_result  (alu_result),
      .o_done        (done),
      .o_taken       (taken),
      .o_redirect    (redirect),
      .o_flush       (flush),
      .o_redirect_pc (redirect_pc),
      .o_err         (err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Cycle 0 = offer/accept. Timeline derived from the branch rules:
   // grant at 1+d, result at grant+l, resolve the cycle after the last wait
   // cycle, timeout when no result within TIMEOUT-1 cycles of grant.
   task automatic run_br(input logic [2:0] f3, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] a,
                         input logic [31:0] b, input logic pr, input int d,
                         input int l, input logic r0, input int kill_at,
                         input logic stray);
      bit legal, pre_kill, kill_wait, resolves, tmo, inv, tk, mis, granted;
      int g, lw, last, res, rdy, arb_end, vc, win;
      logic [1:0]  op;
      logic [31:0] tgt;
      bit e_rdy, e_req, e_done;
      legal = !(f3 inside {3'b010, 3'b011});
      g  = 1 + d;
      lw = (l < TIMEOUT) ? l : TIMEOUT - 1;
      tmo = legal && (l >= TIMEOUT);
      last = legal ? g + lw : 0;
      res = last + 1;
      pre_kill  = legal && kill_at >= 1 && kill_at < g;
      kill_wait = legal && !pre_kill && kill_at >= g && kill_at <= last;
      granted = legal && !pre_kill;
      arb_end = pre_kill ? kill_at : (legal ? g : 0);
      resolves = !pre_kill && !kill_wait;
      if (pre_kill) rdy = kill_at + 1;
      else if (kill_wait) rdy = last + 1;
      else rdy = res + 1;
      inv = f3 inside {3'b001, 3'b100, 3'b110};
      tk = (legal && !tmo) ? (r0 ^ inv) : 1'b0;
      mis = tk ^ pr;
      tgt = tk ? p + im : p + 32'd4;
      case (f3)
         3'b100, 3'b101: op = 2'b01;
         3'b110, 3'b111: op = 2'b10;
         default:        op = 2'b00;
      endcase
      vc = g + l;
      win = (granted && l <= TIMEOUT + 1 && vc > rdy) ? vc : rdy;
      for (int c = 0; c <= win; c++) begin
         br_valid = (c == 0);
         if (c == 0) begin
            func3 = f3; pc = p; imm = im; rs1 = a; rs2 = b; pred = pr;
         end
         alu_gnt = granted && (c == g);
         alu_valid = (granted && l <= TIMEOUT + 1 && c == vc) ||
                     (stray && legal && d > 0 && c == 1);
         alu_result = {$urandom() & 32'hFFFF_FFFE} | {31'd0, r0};
         kill = (c == kill_at);
         @(negedge clk);
         e_rdy  = (c == 0) || (c >= rdy);
         e_req  = legal && c >= 1 && c <= arb_end;
         e_done = resolves && c == res && kill_at != res;
         check("ready", br_ready, e_rdy);
         check("req", alu_req, e_req);
         if (e_req) begin
            check("op", alu_op, op);
            check("a", alu_a, a);
            check("b", alu_b, b);
         end
         check("done", done, e_done);
         check("err", err, e_done && tmo);
         check("redirect", redirect, e_done && mis);
         check("flush", flush, e_done && mis);
         if (e_done) check("taken", taken, tk);
         if (e_done && mis) check("rpc", redirect_pc, tgt);
         @(posedge clk); #1;
      end
      br_valid = 0; alu_gnt = 0; alu_valid = 0; kill = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, br_ready, 1'b1);
      check({tag, "_req"}, alu_req, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_taken"}, taken, 1'b0);
      check({tag, "_redir"}, redirect, 1'b0);
      check({tag, "_flush"}, flush, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_rpc"}, redirect_pc, 32'd0);
   endtask

   initial begin
      logic [2:0] f3;
      int d, l, k;
      #12;
      check_idle_outputs("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // BEQ taken, mispredicted not-taken
      run_br(3'b000, 32'h100, 32'h20, 5, 5, 0, 0, 1, 1'b1, -1, 0);
      // BNE with equal compare: not taken, predicted correctly
      run_br(3'b001, 32'h100, 32'h20, 7, 7, 0, 0, 1, 1'b1, -1, 0);
      // BLTU, GEU true -> not taken, predicted taken -> pc+4
      run_br(3'b110, 32'h100, 32'h40, 9, 3, 1, 0, 2, 1'b1, -1, 0);
      // grant delayed 3 cycles, result never returns
      run_br(3'b101, 32'h200, 32'h10, 1, 2, 1, 3, 20, 1'b1, -1, 0);
      // kill in WAIT, result two cycles later
      run_br(3'b000, 32'h300, 32'h8, 4, 4, 0, 0, 3, 1'b1, 2, 0);
      run_br(3'b000, 32'h300, 32'h8, 4, 4, 0, 0, 1, 1'b1, -1, 0);
      // non-branch func3
      run_br(3'b010, 32'h400, 32'h8, 0, 0, 1, 0, 1, 1'b0, -1, 0);
      run_br(3'b011, 32'h400, 32'h8, 0, 0, 0, 0, 1, 1'b0, -1, 0);
      // redirect target wraps
      run_br(3'b000, 32'hFFFF_FFFC, 32'h8, 1, 1, 0, 0, 1, 1'b1, -1, 0);
      // kill together with grant, drain to timeout
      run_br(3'b100, 32'h500, 32'h4, 1, 2, 0, 1, 20, 1'b0, 2, 0);
      // kill in ARB before grant
      run_br(3'b111, 32'h500, 32'h4, 1, 2, 0, 3, 2, 1'b0, 2, 0);
      // kill during the resolve cycle
      run_br(3'b000, 32'h600, 32'h4, 1, 1, 0, 0, 1, 1'b1, 3, 0);
      // stray result during ARB is ignored
      run_br(3'b001, 32'h700, 32'hC, 1, 2, 1, 2, 4, 1'b0, -1, 1);

      for (int t = 0; t < 200; t++) begin
         f3 = 3'($urandom_range(0, 7));
         d  = $urandom_range(0, 3);
         l  = $urandom_range(1, 17);
         k  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20 + d) : -1;
         run_br(f3, $urandom(), $urandom(), $urandom(), $urandom(),
                1'($urandom_range(0, 1)), d, l, 1'($urandom_range(0, 1)),
                k, 1'($urandom_range(0, 1)));
      end

      // asynchronous reset in the middle of WAIT
      br_valid = 1; func3 = 3'b000; pc = 32'h800; imm = 32'h10;
      @(posedge clk); #1;
      br_valid = 0; alu_gnt = 1;
      @(posedge clk); #1;
      alu_gnt = 0;
      @(posedge clk); #1;
      check("wait_req", alu_req, 1'b0);
      check("wait_ready", br_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("arst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_ready", br_ready, 1'b1);
      check("post_req", alu_req, 1'b0);
      @(posedge clk); #1;
      run_br(3'b101, 32'h900, 32'h20, 3, 2, 0, 1, 2, 1'b1, -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
